// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
// Frame classification helper lives here so the top stays focused on sequencing.
package keypad_pkg;

   localparam int NUM_COLS   = 4;
   localparam int NUM_ROWS   = 4;
   localparam int CODE_W     = 4;
   localparam int FRAME_BITS = NUM_ROWS * NUM_COLS;

   typedef enum logic [1:0] {
      IDLE,
      DEBOUNCE,
      PRESSED
   } state_t;

   typedef enum logic [1:0] {
      NONE,
      SINGLE,
      MULTI
   } frame_cls_t;

   typedef struct packed {
      frame_cls_t        cls;
      logic [CODE_W-1:0] code;
   } frame_t;

   // code is only meaningful when cls == SINGLE
   function automatic frame_t classify(input logic [FRAME_BITS-1:0] snap);
      frame_t      f;
      int unsigned ones;
      ones   = 0;
      f.code = '0;
      for (int unsigned i = 0; i < 16; i++) begin
         if (snap[i[3:0]]) begin
            ones++;
            f.code = i[3:0];
         end
      end
      if (ones == 0)      f.cls = NONE;
      else if (ones == 1) f.cls = SINGLE;
      else                f.cls = MULTI;
      return f;
   endfunction

endpackage

// File: rtl/keypad_row_sync.sv
// Two-flop synchronizer for the asynchronous, active-low keypad row inputs.
// Resets to all-ones (no row pulled low).
module keypad_row_sync
   import keypad_pkg::*;
(
   input  logic                clk,
   input  logic                clr_n,
   input  logic [NUM_ROWS-1:0] i_row,
   output logic [NUM_ROWS-1:0] o_row
);

   logic [NUM_ROWS-1:0] r_meta;
   logic [NUM_ROWS-1:0] r_sync;

   always_ff @(posedge clk) begin
      if (!clr_n) begin
         r_meta <= '1;
         r_sync <= '1;
      end else begin
         r_meta <= i_row;
         r_sync <= r_meta;
      end
   end

   assign o_row = r_sync;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: column strobing, frame-level debounce, valid/ack key hold register.
// Optional auto-repeat while a key is held is enabled by defining KEYPAD_AUTOREPEAT_EN.
module keypad_scanner
   import keypad_pkg::*;
#(
   parameter int SCAN_DIV       = 50000,
   parameter int DEBOUNCE_SCANS = 4,
   parameter int REPEAT_SCANS   = 25
) (
   input  logic                clk,
   input  logic                clr_n,
   output logic [NUM_COLS-1:0] col,
   input  logic [NUM_ROWS-1:0] row,
   output logic [CODE_W-1:0]   key_code,
   output logic                key_valid,
   input  logic                key_ack,
   output logic                overrun
);

   localparam int               DIV_W    = $clog2(SCAN_DIV);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
   localparam logic [3:0]       DEB_LAST = 4'(DEBOUNCE_SCANS);

   if (SCAN_DIV < 4 || DEBOUNCE_SCANS < 1 || DEBOUNCE_SCANS > 15 || REPEAT_SCANS < 1) begin : g_bad_params
      $error("keypad_scanner: parameter out of legal range");
   end

   logic [NUM_ROWS-1:0]   w_row_s;
   logic [DIV_W-1:0]      r_div;
   logic [1:0]            r_col_idx;
   logic [FRAME_BITS-1:0] r_snap;
   logic [FRAME_BITS-1:0] w_snap_next;
   logic                  w_slot_end;
   logic                  w_frame_end;
   frame_t                w_frame;

   state_t                r_state, w_state_next;
   logic [CODE_W-1:0]     r_cand, w_cand_next;
   logic [3:0]            r_cnt, w_cnt_next;
   logic [3:0]            r_rel, w_rel_next;
   logic                  w_emit;

   logic [CODE_W-1:0]     r_code;
   logic                  r_valid;
   logic                  r_overrun;

`ifdef KEYPAD_AUTOREPEAT_EN
   localparam int               REP_W    = $clog2(REPEAT_SCANS + 1);
   localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_SCANS);
   logic [REP_W-1:0]            r_rep, w_rep_next;
`endif

   keypad_row_sync u_row_sync (
      .clk   (clk),
      .clr_n (clr_n),
      .i_row (row),
      .o_row (w_row_s)
   );

   assign w_slot_end  = (r_div == DIV_LAST);
   assign w_frame_end = w_slot_end && (r_col_idx == 2'd3);

   always_comb begin
      col = ~(4'b0001 << r_col_idx);
   end

   // Merge the current column's sample so the frame can be classified on its last slot
   always_comb begin
      w_snap_next = r_snap;
      for (int unsigned r = 0; r < NUM_ROWS; r++) begin
         w_snap_next[{r[1:0], r_col_idx}] = ~w_row_s[r[1:0]];
      end
   end

   assign w_frame = classify(w_snap_next);

   always_ff @(posedge clk) begin
      if (!clr_n) begin
         r_div     <= '0;
         r_col_idx <= '0;
         r_snap    <= '0;
      end else if (w_slot_end) begin
         r_div     <= '0;
         r_col_idx <= r_col_idx + 2'd1;
         r_snap    <= w_frame_end ? '0 : w_snap_next;
      end else begin
         r_div     <= r_div + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!clr_n) begin
         r_state <= IDLE;
         r_cand  <= '0;
         r_cnt   <= '0;
         r_rel   <= '0;
`ifdef KEYPAD_AUTOREPEAT_EN
         r_rep   <= '0;
`endif
      end else begin
         r_state <= w_state_next;
         r_cand  <= w_cand_next;
         r_cnt   <= w_cnt_next;
         r_rel   <= w_rel_next;
`ifdef KEYPAD_AUTOREPEAT_EN
         r_rep   <= w_rep_next;
`endif
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_cand_next  = r_cand;
      w_cnt_next   = r_cnt;
      w_rel_next   = r_rel;
      w_emit       = 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
      w_rep_next   = r_rep;
`endif
      if (w_frame_end) begin
         case (r_state)
            IDLE: begin
               if (w_frame.cls == SINGLE) begin
                  w_cand_next = w_frame.code;
                  w_cnt_next  = 4'd1;
                  if (DEB_LAST == 4'd1) begin
                     w_emit       = 1'b1;
                     w_state_next = PRESSED;
                     w_rel_next   = '0;
`ifdef KEYPAD_AUTOREPEAT_EN
                     w_rep_next   = '0;
`endif
                  end else begin
                     w_state_next = DEBOUNCE;
                  end
               end
            end
            DEBOUNCE: begin
               if (w_frame.cls == SINGLE && w_frame.code == r_cand) begin
                  w_cnt_next = r_cnt + 4'd1;
                  if (w_cnt_next == DEB_LAST) begin
                     w_emit       = 1'b1;
                     w_state_next = PRESSED;
                     w_rel_next   = '0;
`ifdef KEYPAD_AUTOREPEAT_EN
                     w_rep_next   = '0;
`endif
                  end
               end else begin
                  w_state_next = IDLE;
               end
            end
            PRESSED: begin
               if (w_frame.cls == NONE) begin
                  w_rel_next = r_rel + 4'd1;
                  if (w_rel_next == DEB_LAST) w_state_next = IDLE;
`ifdef KEYPAD_AUTOREPEAT_EN
                  w_rep_next = '0;
`endif
               end else begin
                  w_rel_next = '0;
`ifdef KEYPAD_AUTOREPEAT_EN
                  if (w_frame.cls == SINGLE && w_frame.code == r_cand) begin
                     w_rep_next = r_rep + 1'b1;
                     if (w_rep_next == REP_LAST) begin
                        w_emit     = 1'b1;
                        w_rep_next = '0;
                     end
                  end else begin
                     w_rep_next = '0;
                  end
`endif
               end
            end
            default: w_state_next = IDLE;
         endcase
      end
   end

   // An emit coinciding with an ack replaces the held key without flagging overrun
   always_ff @(posedge clk) begin
      if (!clr_n) begin
         r_code    <= '0;
         r_valid   <= 1'b0;
         r_overrun <= 1'b0;
      end else if (w_emit) begin
         if (!r_valid || key_ack) begin
            r_code  <= r_cand;
            r_valid <= 1'b1;
         end else begin
            r_overrun <= 1'b1;
         end
      end else if (key_ack && r_valid) begin
         r_valid <= 1'b0;
      end
   end

   assign key_code  = r_code;
   assign key_valid = r_valid;
   assign overrun   = r_overrun;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed testbench for keypad_scanner (SCAN_DIV=4, DEBOUNCE_SCANS=2, REPEAT_SCANS=3).
// Models the keypad matrix from a 16-bit pressed-key vector; build with KEYPAD_AUTOREPEAT_EN to cover auto-repeat.
module tb_keypad_scanner;

   logic        clk = 1'b0;
   logic        clr_n;
   logic [3:0]  col;
   logic [3:0]  row;
   logic [3:0]  key_code;
   logic        key_valid;
   logic        key_ack;
   logic        overrun;
   logic [15:0] keys;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   always #5 clk = ~clk;

   // Row r is pulled low when a pressed key in row r sits on the strobed column
   always_comb begin
      for (int r = 0; r < 4; r++) row[r] = ~|(keys[r*4 +: 4] & ~col);
   end

   keypad_scanner #(
      .SCAN_DIV       (4),
      .DEBOUNCE_SCANS (2),
      .REPEAT_SCANS   (3)
   ) dut (
      .clk       (clk),
      .clr_n     (clr_n),
      .col       (col),
      .row       (row),
      .key_code  (key_code),
      .key_valid (key_valid),
      .key_ack   (key_ack),
      .overrun   (overrun)
   );

   task automatic step(input int n);
      repeat (n) @(negedge clk);
      cyc += n;
   endtask

   task automatic do_reset();
      @(negedge clk);
      clr_n   = 1'b0;
      key_ack = 1'b0;
      keys    = '0;
      repeat (3) @(negedge clk);
      clr_n = 1'b1;
      cyc   = 0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      clr_n   = 1'b0;
      key_ack = 1'b0;
      keys    = '0;
      repeat (3) @(negedge clk);
      checks++; if (col !== 4'b1110) begin errors++; $display("FAIL reset_col: got %b want 1110", col); end
      checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", key_valid); end
      checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b want 0", overrun); end
      checks++; if (key_code !== 4'd0) begin errors++; $display("FAIL reset_code: got %0d want 0", key_code); end
      clr_n = 1'b1;
      cyc   = 0;
      step(3);
      checks++; if (col !== 4'b1110) begin errors++; $display("FAIL rot_c0: got %b want 1110", col); end
      step(1);
      checks++; if (col !== 4'b1101) begin errors++; $display("FAIL rot_c1: got %b want 1101", col); end
      step(4);
      checks++; if (col !== 4'b1011) begin errors++; $display("FAIL rot_c2: got %b want 1011", col); end
      step(4);
      checks++; if (col !== 4'b0111) begin errors++; $display("FAIL rot_c3: got %b want 0111", col); end
      step(4);
      checks++; if (col !== 4'b1110) begin errors++; $display("FAIL rot_wrap: got %b want 1110", col); end
   endtask

   task automatic test_single_press();
      do_reset();
      keys = 16'h0040;
      step(31);
      checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL single_early: valid=%b want 0", key_valid); end
      step(1);
      checks++; if (key_valid !== 1'b1) begin errors++; $display("FAIL single_valid: valid=%b want 1", key_valid); end
      checks++; if (key_code !== 4'd6) begin errors++; $display("FAIL single_code: got %0d want 6", key_code); end
      step(16);
      checks++; if (key_valid !== 1'b1) begin errors++; $display("FAIL single_hold: valid=%b want 1", key_valid); end
      key_ack = 1'b1;
      step(1);
      key_ack = 1'b0;
      checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL single_ack: valid=%b want 0", key_valid); end
      step(31);
      checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL single_no_second: valid=%b want 0", key_valid); end
      checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL single_overrun: got %b want 0", overrun); end
      keys = '0;
   endtask

   task automatic test_multi_key();
      do_reset();
      keys = 16'h0240;
      for (int f = 0; f < 5; f++) begin
         step(16);
         checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL multi_frame%0d: valid=%b want 0", f, key_valid); end
      end
      keys = '0;
      step(32);
      keys = 16'h0040;
      step(31);
      checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL multi_after_early: valid=%b want 0", key_valid); end
      step(1);
      checks++; if (key_valid !== 1'b1 || key_code !== 4'd6) begin
         errors++; $display("FAIL multi_after_press: valid=%b code=%0d want 1/6", key_valid, key_code);
      end
   endtask

   task automatic test_bounce();
      do_reset();
      for (int i = 0; i < 4; i++) begin
         keys = 16'h0020;
         step(16);
         checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL bounce_on%0d: valid=%b want 0", i, key_valid); end
         keys = '0;
         step(16);
         checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL bounce_off%0d: valid=%b want 0", i, key_valid); end
      end
      keys = 16'h0020;
      step(31);
      checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL bounce_steady_early: valid=%b want 0", key_valid); end
      step(1);
      checks++; if (key_valid !== 1'b1 || key_code !== 4'd5) begin
         errors++; $display("FAIL bounce_steady: valid=%b code=%0d want 1/5", key_valid, key_code);
      end
   endtask

   task automatic test_ack_same_cycle();
      do_reset();
      keys = 16'h0008;
      step(32);
      checks++; if (key_valid !== 1'b1 || key_code !== 4'd3) begin
         errors++; $display("FAIL samecyc_first: valid=%b code=%0d want 1/3", key_valid, key_code);
      end
      keys = '0;
      step(32);
      keys = 16'h1000;
      step(31);
      key_ack = 1'b1;
      step(1);
      key_ack = 1'b0;
      checks++; if (key_code !== 4'd12) begin errors++; $display("FAIL samecyc_code: got %0d want 12", key_code); end
      checks++; if (key_valid !== 1'b1) begin errors++; $display("FAIL samecyc_valid: got %b want 1", key_valid); end
      checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL samecyc_overrun: got %b want 0", overrun); end
      step(1);
      checks++; if (key_valid !== 1'b1) begin errors++; $display("FAIL samecyc_valid_after: got %b want 1", key_valid); end
   endtask

   task automatic test_overrun();
      do_reset();
      keys = 16'h0008;
      step(32);
      keys = '0;
      step(32);
      keys = 16'h1000;
      step(31);
      checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL overrun_early: got %b want 0", overrun); end
      step(1);
      checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_set: got %b want 1", overrun); end
      checks++; if (key_code !== 4'd3) begin errors++; $display("FAIL overrun_code: got %0d want 3", key_code); end
      checks++; if (key_valid !== 1'b1) begin errors++; $display("FAIL overrun_valid: got %b want 1", key_valid); end
      key_ack = 1'b1;
      step(1);
      key_ack = 1'b0;
      checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL overrun_ack: valid=%b want 0", key_valid); end
      checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_sticky: got %b want 1", overrun); end
   endtask

   task automatic test_repeat();
      logic exp;
      do_reset();
      keys = 16'h8000;
      for (int f = 1; f <= 10; f++) begin
         step(15);
         key_ack = 1'b0;
         checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL repeat_pre_f%0d: valid=%b want 0", f, key_valid); end
         step(1);
`ifdef KEYPAD_AUTOREPEAT_EN
         exp = (f == 2 || f == 5 || f == 8);
`else
         exp = (f == 2);
`endif
         checks++; if (key_valid !== exp) begin errors++; $display("FAIL repeat_f%0d: valid=%b want %b", f, key_valid, exp); end
         if (exp) begin
            checks++; if (key_code !== 4'd15) begin errors++; $display("FAIL repeat_code_f%0d: got %0d want 15", f, key_code); end
         end
         key_ack = exp;
      end
      key_ack = 1'b0;
      keys    = '0;
   endtask

   initial begin
      clr_n   = 1'b0;
      key_ack = 1'b0;
      keys    = '0;
      test_reset();
      test_single_press();
      test_multi_key();
      test_bounce();
      test_ack_same_cycle();
      test_overrun();
      test_repeat();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
